// File: rtl/serial_link_pkg.sv
// serial_link_pkg: shared types and constants for the serial word link
package serial_link_pkg;
  localparam int SERIAL_WIDTH = 32;
  typedef enum logic {IDLE, RECV} state_e;
  typedef logic [1:0] residue_t;
  localparam residue_t R0 = 2'd0;
  localparam residue_t R1 = 2'd1;
  localparam residue_t R2 = 2'd2;
  // bit i weighs 2^i mod 3: 1 on even phase, 2 on odd phase
  function automatic residue_t mod3_step(input residue_t r, input logic b, input logic ph);
    logic [2:0] s;
    s = {1'b0, r} + (b ? (ph ? 3'd2 : 3'd1) : 3'd0);
    return s >= 3'd3 ? residue_t'(s - 3'd3) : residue_t'(s);
  endfunction
endpackage

// File: rtl/mod3_residue_tracker.sv
// mod3_residue_tracker: running residue mod 3 of an LSB-first bit stream
module mod3_residue_tracker
  import serial_link_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     clr,
  input  logic     en,
  input  logic     bit_in,
  output residue_t residue,
  output residue_t residue_next
);
  logic     phase_q;
  residue_t residue_q;
  assign residue = residue_q;
  assign residue_next = mod3_step(residue_q, bit_in, phase_q);
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      residue_q <= R0;
      phase_q   <= 1'b0;
    end else if (en) begin
      residue_q <= residue_next;
      phase_q   <= ~phase_q;
    end
  end
endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: LSB-first serial-to-parallel word receiver with divisible-by-3 flag
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inp,
  input  logic             inp_en,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             div3,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q, sr_d, out_q;
  logic             valid_q, div3_q, done;
  residue_t         residue_next;
  assign sr_d = {inp, sr_q[WIDTH-1:1]};
  assign done = inp_en && cnt_q == LAST;
  mod3_residue_tracker u_mod3 (
    .clk          (clk),
    .reset        (reset),
    .clr          (done),
    .en           (inp_en),
    .bit_in       (inp),
    .residue      (),
    .residue_next (residue_next)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      div3_q  <= 1'b0;
    end else begin
      valid_q <= done;
      if (inp_en) begin
        sr_q    <= sr_d;
        cnt_q   <= done ? '0 : cnt_q + CW'(1);
        state_q <= done ? IDLE : RECV;
      end
      if (done) begin
        out_q  <= sr_d;
        div3_q <= residue_next == R0;
      end
    end
  end
  assign out       = out_q;
  assign out_valid = valid_q;
  assign div3      = div3_q;
  assign busy      = state_q == RECV;
endmodule
